dma_axil_arb: RTL

DMA_AXIL_ARB -- requirements
Module: dma_axil_arb

---
 rtl/dma_axil_arb.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/dma_axil_arb.sv
// Two-requester arbiter funnelling register reads/writes onto one AXI-Lite master port.
// Round-robin between requesters, one transaction in flight at a time.
module dma_axil_arb #(
   parameter logic [15:0] BASE_HI = 16'h0000
) (
   input  logic        usr_clk,
   input  logic        usr_rst_n,

   input  logic        req0_valid,
   input  logic        req0_wr,
   input  logic [15:0] req0_addr,
   input  logic [31:0] req0_wdata,
   output logic        req0_ready,
   output logic        req0_done,
   output logic [31:0] req0_rdata,
   output logic        req0_err,

   input  logic        req1_valid,
   input  logic        req1_wr,
   input  logic [15:0] req1_addr,
   input  logic [31:0] req1_wdata,
   output logic        req1_ready,
   output logic        req1_done,
   output logic [31:0] req1_rdata,
   output logic        req1_err,

   output logic [31:0] s_axil_awaddr_o,
   output logic [2:0]  s_axil_awprot_o,
   output logic        s_axil_awvalid_o,
   input  logic        s_axil_awready_i,
   output logic [31:0] s_axil_wdata_o,
   output logic [3:0]  s_axil_wstrb_o,
   output logic        s_axil_wvalid_o,
   input  logic        s_axil_wready_i,
   input  logic        s_axil_bvalid_i,
   input  logic [1:0]  s_axil_bresp_i,
   output logic        s_axil_bready_o,
   output logic [31:0] s_axil_araddr_o,
   output logic [2:0]  s_axil_arprot_o,
   output logic        s_axil_arvalid_o,
   input  logic        s_axil_arready_i,
   input  logic [31:0] s_axil_rdata_i,
   input  logic [1:0]  s_axil_rresp_i,
   input  logic        s_axil_rvalid_i,
   output logic        s_axil_rready_o
);

   // state   | meaning
   // S_IDLE  | no transaction, arbitrate and grant
   // S_RADDR | AR presented, waiting for arready
   // S_RDATA | waiting for R beat
   // S_WADDR | AW and W presented, each retires on its own handshake
   // S_WRESP | waiting for B beat
   typedef enum logic [2:0] {
      S_IDLE,
      S_RADDR,
      S_RDATA,
      S_WADDR,
      S_WRESP
   } state_t;

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        sel_q, sel_d;
   logic [15:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        done0_q, done0_d;
   logic        done1_q, done1_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;
   logic        err0_q, err0_d;
   logic        err1_q, err1_d;

   logic        gnt;
   logic        gnt_id;
   logic        aw_fin;
   logic        w_fin;

   always_comb begin
      state_d          = state_q;
      last_d           = last_q;
      sel_d            = sel_q;
      addr_d           = addr_q;
      wdata_d          = wdata_q;
      aw_done_d        = aw_done_q;
      w_done_d         = w_done_q;
      done0_d          = 1'b0;
      done1_d          = 1'b0;
      rdata0_d         = rdata0_q;
      rdata1_d         = rdata1_q;
      err0_d           = err0_q;
      err1_d           = err1_q;
      req0_ready       = 1'b0;
      req1_ready       = 1'b0;
      s_axil_arvalid_o = 1'b0;
      s_axil_awvalid_o = 1'b0;
      s_axil_wvalid_o  = 1'b0;
      s_axil_rready_o  = 1'b0;
      s_axil_bready_o  = 1'b0;
      gnt              = 1'b0;
      gnt_id           = 1'b0;
      aw_fin           = 1'b0;
      w_fin            = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req0_valid && req1_valid) begin
               gnt    = 1'b1;
               gnt_id = ~last_q;
            end else if (req0_valid || req1_valid) begin
               gnt    = 1'b1;
               gnt_id = req1_valid;
            end
            if (gnt) begin
               last_d = gnt_id;
               sel_d  = gnt_id;
               if (gnt_id) begin
                  req1_ready = 1'b1;
                  addr_d     = req1_addr;
                  wdata_d    = req1_wdata;
                  state_d    = req1_wr ? S_WADDR : S_RADDR;
               end else begin
                  req0_ready = 1'b1;
                  addr_d     = req0_addr;
                  wdata_d    = req0_wdata;
                  state_d    = req0_wr ? S_WADDR : S_RADDR;
               end
            end
         end
         S_RADDR: begin
            s_axil_arvalid_o = 1'b1;
            if (s_axil_arready_i) state_d = S_RDATA;
         end
         S_RDATA: begin
            s_axil_rready_o = 1'b1;
            if (s_axil_rvalid_i) begin
               state_d = S_IDLE;
               if (sel_q) begin
                  rdata1_d = s_axil_rdata_i;
                  err1_d   = (s_axil_rresp_i != 2'b00);
                  done1_d  = 1'b1;
               end else begin
                  rdata0_d = s_axil_rdata_i;
                  err0_d   = (s_axil_rresp_i != 2'b00);
                  done0_d  = 1'b1;
               end
            end
         end
         S_WADDR: begin
            s_axil_awvalid_o = ~aw_done_q;
            s_axil_wvalid_o  = ~w_done_q;
            aw_fin = aw_done_q | s_axil_awready_i;
            w_fin  = w_done_q | s_axil_wready_i;
            if (aw_fin && w_fin) begin
               state_d   = S_WRESP;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end else begin
               aw_done_d = aw_fin;
               w_done_d  = w_fin;
            end
         end
         S_WRESP: begin
            s_axil_bready_o = 1'b1;
            if (s_axil_bvalid_i) begin
               state_d = S_IDLE;
               if (sel_q) begin
                  err1_d  = (s_axil_bresp_i != 2'b00);
                  done1_d = 1'b1;
               end else begin
                  err0_d  = (s_axil_bresp_i != 2'b00);
                  done0_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge usr_clk or negedge usr_rst_n) begin
      if (!usr_rst_n) begin
         state_q   <= S_IDLE;
         last_q    <= 1'b1;
         sel_q     <= 1'b0;
         addr_q    <= 16'h0000;
         wdata_q   <= 32'h0000_0000;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         rdata0_q  <= 32'h0000_0000;
         rdata1_q  <= 32'h0000_0000;
         err0_q    <= 1'b0;
         err1_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         sel_q     <= sel_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         done0_q   <= done0_d;
         done1_q   <= done1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
         err0_q    <= err0_d;
         err1_q    <= err1_d;
      end
   end

   assign req0_done       = done0_q;
   assign req1_done       = done1_q;
   assign req0_rdata      = rdata0_q;
   assign req1_rdata      = rdata1_q;
   assign req0_err        = err0_q;
   assign req1_err        = err1_q;

   assign s_axil_araddr_o = {BASE_HI, addr_q};
   assign s_axil_awaddr_o = {BASE_HI, addr_q};
   assign s_axil_arprot_o = 3'b000;
   assign s_axil_awprot_o = 3'b000;
   assign s_axil_wdata_o  = wdata_q;
   assign s_axil_wstrb_o  = 4'hF;

endmodule
